screen_controller: RTL
======================

Name: screen_controller

Overview:
Screen-sequencing FSM for the Pong display path. It turns debounced button levels and the packed score into the screen_mode, icon_highlighter and speed_selector controls that the VGA top level uses to choose and drive its menu, game, options, credits and winner screens. Internal state changes immediately. The display-facing outputs are committed only at the start of vertical blanking, so a screen never switches mid-frame. The block also issues a game-start pulse and a game-active level to the game logic.

Parameters:
WIN_SCORE, 4'd9, nibble value that ends a game
WIN_HOLD_FRAMES, 10'd180, frames the winner screen stays up before auto-return (1..1023)
DEFAULT_SPEED, 2'd1, speed_selector value after reset

Ports:
pclk  input  1  65 MHz pixel clock, the only clock
rst  input  1  asynchronous, active-low reset
btn_up  input  1  synchronous debounced level
btn_down  input  1  synchronous debounced level
btn_select  input  1  synchronous debounced level
btn_back  input  1  synchronous debounced level
score  input  8  [7:4] left player, [3:0] right player
vblnk  input  1  vertical blank from vga_timing
screen_mode  output  3  committed screen: 000 menu, 001 game, 011 options, 010 credits, 100 P1 wins, 101 P2 wins
icon_highlighter  output  2  committed menu cursor, 0 play, 1 options, 2 credits
speed_selector  output  2  committed ball speed, 0..3
game_start  output  1  one-cycle pulse on entry to GAME
game_active  output  1  high while internal state is GAME (not frame-gated)

Behaviour:
- Reset (rst=0, asynchronous):
  - state = MENU, cursor = 0, speed = DEFAULT_SPEED, hold counter = 0, edge-detect registers = 0.
  - Outputs: screen_mode = 000, icon_highlighter = 0, speed_selector = DEFAULT_SPEED, game_start = 0, game_active = 0.
  - Reset asserted mid-game or mid-hold aborts immediately to these values.
- Button edge detect: press = level & ~level_d (level_d is the level registered one cycle earlier).
  - Holding a button produces one press only.
  - Only one press acts per cycle, priority select > back > up > down; lower-priority presses that cycle are discarded.
  - The state transition takes effect at the same clock edge that samples the press.
- MENU:
  - up: cursor = cursor - 1, wrapping 0 -> 2.
  - down: cursor = cursor + 1, wrapping 2 -> 0.
  - The cursor never holds 3.
  - select: cursor 0 -> GAME, cursor 1 -> OPTIONS, cursor 2 -> CREDITS.
  - back: ignored.
- GAME:
  - game_start = 1 for exactly the first cycle in GAME. Score is not evaluated that cycle.
  - Afterwards, each cycle: score[7:4] >= WIN_SCORE -> P1WIN; else score[3:0] >= WIN_SCORE -> P2WIN. If both reach it in the same cycle, P1 wins.
  - back -> MENU, cursor = 0. select, up and down are ignored.
  - A win takes precedence over back in the same cycle.
- OPTIONS:
  - up: speed + 1, saturating at 3.
  - down: speed - 1, saturating at 0.
  - select or back -> MENU, cursor = 1.
- CREDITS: select or back -> MENU, cursor = 2. Other buttons ignored.
- P1WIN / P2WIN:
  - The hold counter clears on entry.
  - It increments on each vblnk rising edge (vblnk & ~vblnk_d).
  - When the counter reaches WIN_HOLD_FRAMES, or select is pressed -> MENU, cursor = 0.
  - Other buttons ignored.
- Output commit:
  - On a cycle where vblnk & ~vblnk_d is true, the next edge loads screen_mode, icon_highlighter and speed_selector from the internal state, cursor and speed as they stood before that edge.
  - A change made at the same edge as the commit appears one frame later.
  - Between commits the outputs hold their values.
- game_active and game_start are registered from internal state and are not frame-gated.
- Encoding: P1WIN = 100 and P2WIN = 101, so bit 0 carries the winner id. No other encodings are ever produced.

Test Plan:
- Reset, then toggle vblnk -> screen_mode = 000, icon = 0, speed = 1, game_start = 0.
- In MENU, press up once then vblnk edge -> icon = 2. Press down twice then vblnk edge -> icon = 1. Hold btn_down for 100 cycles -> exactly one increment.
- icon = 0, press select -> game_active = 1 next cycle, game_start high for 1 cycle. screen_mode stays 000 until the vblnk rising edge, then 001.
- In GAME, drive score = 8'h98 -> state P1WIN, screen_mode = 100 after next vblnk edge. Drive 8'h99 in a fresh game -> 100. Drive 8'h29 -> 101.
- In P1WIN, pulse vblnk 180 times, no buttons -> MENU with icon = 0, screen_mode = 000 after the following vblnk edge. Repeat with select after 5 frames -> early return.
- Enter OPTIONS, press up 5 times -> speed = 3. Press down 6 times -> speed = 0. Press back -> icon = 1. Press select and back in the same cycle in CREDITS -> one exit only, icon = 2.
- Assert rst=0 mid-GAME between clock edges -> all outputs reset asynchronously without waiting for pclk.

Source files
------------

// File: rtl/screen_controller.sv
// Screen sequencer for the Pong display path.
// Button presses move an internal FSM immediately; the display-facing
// controls (screen_mode, icon_highlighter, speed_selector) are only
// refreshed on the rising edge of vblnk so a screen never tears mid-frame.
//
// state    | meaning
// ---------+--------------------------------------------------------
// MENU     | main menu, cursor selects play / options / credits
// GAME     | match running, watching score for a winner
// OPTIONS  | ball speed adjust with up/down
// CREDITS  | static credits page
// P1WIN    | left player won, held for WIN_HOLD_FRAMES frames
// P2WIN    | right player won, held for WIN_HOLD_FRAMES frames
//
// The state encoding equals the screen_mode code, so committing the
// screen is a straight copy of the state register.

module screen_controller #(
  parameter logic [3:0] WIN_SCORE       = 4'd9,
  parameter logic [9:0] WIN_HOLD_FRAMES = 10'd180,
  parameter logic [1:0] DEFAULT_SPEED   = 2'd1
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic [7:0] score,
  input  logic       vblnk,
  output logic [2:0] screen_mode,
  output logic [1:0] icon_highlighter,
  output logic [1:0] speed_selector,
  output logic       game_start,
  output logic       game_active
);

  typedef enum logic [2:0] {
    MENU    = 3'b000,
    GAME    = 3'b001,
    CREDITS = 3'b010,
    OPTIONS = 3'b011,
    P1WIN   = 3'b100,
    P2WIN   = 3'b101
  } state_t;

  state_t     state;
  logic [1:0] cursor;
  logic [1:0] speed;
  logic [9:0] hold_cnt;

  logic       up_d;
  logic       down_d;
  logic       select_d;
  logic       back_d;
  logic       vblnk_d;

  logic       press_up;
  logic       press_down;
  logic       press_select;
  logic       press_back;
  logic       act_up;
  logic       act_down;
  logic       act_select;
  logic       act_back;
  logic       vblnk_rise;
  logic       p1_reached;
  logic       p2_reached;

  // Rising-edge detect and single-winner arbitration: select > back > up > down.
  always_comb begin
    press_up     = btn_up & ~up_d;
    press_down   = btn_down & ~down_d;
    press_select = btn_select & ~select_d;
    press_back   = btn_back & ~back_d;

    act_select   = press_select;
    act_back     = press_back & ~press_select;
    act_up       = press_up & ~press_select & ~press_back;
    act_down     = press_down & ~press_select & ~press_back & ~press_up;

    vblnk_rise   = vblnk & ~vblnk_d;
    p1_reached   = (score[7:4] >= WIN_SCORE);
    p2_reached   = (score[3:0] >= WIN_SCORE);
  end

  // Delayed copies of the button and vblnk levels for edge detection.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      up_d     <= 1'b0;
      down_d   <= 1'b0;
      select_d <= 1'b0;
      back_d   <= 1'b0;
      vblnk_d  <= 1'b0;
    end else begin
      up_d     <= btn_up;
      down_d   <= btn_down;
      select_d <= btn_select;
      back_d   <= btn_back;
      vblnk_d  <= vblnk;
    end
  end

  // Screen FSM with registered game_start / game_active.
  // game_start doubles as the "first cycle in GAME" flag that masks the
  // score check, so a stale score from the previous match cannot end the
  // new one before the game logic has cleared it.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state       <= MENU;
      cursor      <= 2'd0;
      speed       <= DEFAULT_SPEED;
      hold_cnt    <= 10'd0;
      game_start  <= 1'b0;
      game_active <= 1'b0;
    end else begin
      game_start <= 1'b0;
      case (state)
        MENU: begin
          if (act_select) begin
            case (cursor)
              2'd0: begin
                state       <= GAME;
                game_start  <= 1'b1;
                game_active <= 1'b1;
              end
              2'd1:    state <= OPTIONS;
              default: state <= CREDITS;
            endcase
          end else if (act_up) begin
            cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
          end else if (act_down) begin
            cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
          end
        end

        GAME: begin
          if (!game_start && p1_reached) begin
            state       <= P1WIN;
            hold_cnt    <= 10'd0;
            game_active <= 1'b0;
          end else if (!game_start && p2_reached) begin
            state       <= P2WIN;
            hold_cnt    <= 10'd0;
            game_active <= 1'b0;
          end else if (act_back) begin
            state       <= MENU;
            cursor      <= 2'd0;
            game_active <= 1'b0;
          end
        end

        OPTIONS: begin
          if (act_select || act_back) begin
            state  <= MENU;
            cursor <= 2'd1;
          end else if (act_up) begin
            if (speed != 2'd3) speed <= speed + 2'd1;
          end else if (act_down) begin
            if (speed != 2'd0) speed <= speed - 2'd1;
          end
        end

        CREDITS: begin
          if (act_select || act_back) begin
            state  <= MENU;
            cursor <= 2'd2;
          end
        end

        P1WIN, P2WIN: begin
          if (act_select || (hold_cnt == WIN_HOLD_FRAMES)) begin
            state  <= MENU;
            cursor <= 2'd0;
          end else if (vblnk_rise) begin
            hold_cnt <= hold_cnt + 10'd1;
          end
        end

        default: begin
          state       <= MENU;
          cursor      <= 2'd0;
          game_active <= 1'b0;
        end
      endcase
    end
  end

  // Frame-synchronous commit of the display controls at vblank start.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      screen_mode      <= 3'b000;
      icon_highlighter <= 2'd0;
      speed_selector   <= DEFAULT_SPEED;
    end else if (vblnk_rise) begin
      screen_mode      <= state;
      icon_highlighter <= cursor;
      speed_selector   <= speed;
    end
  end

endmodule
